// File: rtl/banco_registros_pkg.sv
// banco_pkg: shared constants for the register bank.
//   N_DEFAULT, DEPTH_DEFAULT : default data width and register count
//   state_t, IDLE, SWEEP     : sweep FSM state encoding
//   PRESET, preset_word()    : reload values; indices 16 and up return 0
package banco_pkg;

  localparam int unsigned N_DEFAULT     = 16;
  localparam int unsigned DEPTH_DEFAULT = 16;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t SWEEP = 1'b1;

  localparam logic [15:0] PRESET [16] = '{
    16'h0001, 16'h0001, 16'h0001, 16'h0001,
    16'h0000, 16'h0000, 16'h0025, 16'h0000,
    16'h0000, 16'h0404, 16'h0004, 16'h0004,
    16'h0004, 16'h8004, 16'hA204, 16'h8004
  };

  function automatic logic [15:0] preset_word(input logic [31:0] idx);
    logic [3:0] i4;
    i4 = idx[3:0];
    return (idx < 32'd16) ? PRESET[i4] : 16'h0000;
  endfunction

endpackage

// File: rtl/banco_registros_if.sv
// banco_registros_if: bus between a client (master) and the register bank (slave).
//   w, select_register, s : write request, address, data
//   ra, rb / qa, qb       : read addresses and registered read data
//   clr                   : request a preset reload sweep
//   busy, w_err           : sweep in progress, dropped-write pulse
interface banco_registros_if
  import banco_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          w;
  logic [AW-1:0] select_register;
  logic [N-1:0]  s;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [N-1:0]  qa;
  logic [N-1:0]  qb;
  logic          clr;
  logic          busy;
  logic          w_err;

  modport master (
    output w, select_register, s, ra, rb, clr,
    input  qa, qb, busy, w_err
  );

  modport slave (
    input  w, select_register, s, ra, rb, clr,
    output qa, qb, busy, w_err
  );
endinterface

// File: rtl/banco_registros_barrido.sv
// banco_barrido: preset sweep FSM and index counter.
//   clk, rst  : clock, synchronous active-high reset (starts a sweep)
//   clr       : start a sweep from IDLE (ignored while sweeping)
//   busy      : high in SWEEP
//   sweep_we  : write PRESET[sweep_idx] at this edge
//   sweep_idx : register being reloaded
module banco_barrido
  import banco_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  output logic                     sweep_we,
  output logic [$clog2(DEPTH)-1:0] sweep_idx
);
  localparam int unsigned AW = $clog2(DEPTH);

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= SWEEP;
            cnt   <= '0;
          end
        end
        default: begin
          // cnt wraps back to 0 on the last write since DEPTH is a power of two
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == SWEEP);
  assign sweep_we  = busy && !rst;
  assign sweep_idx = cnt;
endmodule

// File: rtl/banco_registros.sv
// banco_registros: DEPTH x N register bank, one write port, two registered
// read ports, preset reload sweep after reset or on clr.
//   clk, rst : clock, synchronous active-high reset
//   bus      : banco_registros_if.slave (w/select_register/s, ra/rb -> qa/qb,
//              clr, busy, w_err)
// Optional: BANCO_BYPASS_EN makes a read of the address being written by an
// accepted user write return the new data at the same edge.
module banco_registros
  import banco_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  banco_registros_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [N-1:0]  regs [DEPTH];
  logic          sweep_we;
  logic [AW-1:0] sweep_idx;
  logic          user_we;

  banco_barrido #(.DEPTH(DEPTH)) u_barrido (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.clr),
    .busy      (bus.busy),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx)
  );

  assign user_we = bus.w && !bus.busy && !rst;

  // Storage has no reset; the sweep reloads it.
  always_ff @(posedge clk) begin
    if (sweep_we)
      regs[sweep_idx] <= N'(preset_word(32'(sweep_idx)));
    else if (user_we)
      regs[bus.select_register] <= bus.s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.qa    <= '0;
      bus.qb    <= '0;
      bus.w_err <= 1'b0;
    end else begin
      bus.w_err <= bus.w && bus.busy;
`ifdef BANCO_BYPASS_EN
      bus.qa <= (user_we && bus.select_register == bus.ra) ? bus.s : regs[bus.ra];
      bus.qb <= (user_we && bus.select_register == bus.rb) ? bus.s : regs[bus.rb];
`else
      bus.qa <= regs[bus.ra];
      bus.qb <= regs[bus.rb];
`endif
    end
  end
endmodule

// File: tb/tb_banco_registros.sv
module tb_banco_registros;
  logic clk = 1'b0;
  logic rst;
  logic rst8;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned n;

  always #5 clk = ~clk;

  banco_registros_if #(.N(16), .DEPTH(16)) bus ();
  banco_registros_if #(.N(8),  .DEPTH(32)) bus8 ();

  banco_registros #(.N(16), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  banco_registros #(.N(8),  .DEPTH(32)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

  logic [15:0] exp_preset [16] = '{
    16'h0001, 16'h0001, 16'h0001, 16'h0001,
    16'h0000, 16'h0000, 16'h0025, 16'h0000,
    16'h0000, 16'h0404, 16'h0004, 16'h0004,
    16'h0004, 16'h8004, 16'hA204, 16'h8004
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst8 = 1'b1;
    bus.w = 0; bus.select_register = '0; bus.s = '0; bus.ra = '0; bus.rb = '0; bus.clr = 0;
    bus8.w = 0; bus8.select_register = '0; bus8.s = '0; bus8.ra = '0; bus8.rb = '0; bus8.clr = 0;
    tick();
    tick();
    check("rst_busy",  32'(bus.busy), 32'd1);
    check("rst_qa",    32'(bus.qa), 32'd0);
    check("rst_qb",    32'(bus.qb), 32'd0);
    check("rst_w_err", 32'(bus.w_err), 32'd0);
    rst = 1'b0;

    // Scenario 1: sweep after reset
    n = 0;
    while (bus.busy && n < 100) begin n++; tick(); end
    check("busy_len_reset", n, 32'd16);
    bus.ra = 4'd6; bus.rb = 4'd14;
    tick();
    check("qa_idx6",  32'(bus.qa), 32'h0025);
    check("qb_idx14", 32'(bus.qb), 32'hA204);
    for (int unsigned k = 0; k < 16; k++) begin
      bus.ra = 4'(k);
      tick();
      check($sformatf("preset_%0d", k), 32'(bus.qa), 32'(exp_preset[k]));
    end

    // Scenario 2: user write in IDLE
    bus.ra = 4'd0;
    bus.w = 1; bus.select_register = 4'd3; bus.s = 16'hBEEF;
    tick();
    check("w_err_idle", 32'(bus.w_err), 32'd0);
    bus.w = 0; bus.ra = 4'd3;
    tick();
    check("qa_beef", 32'(bus.qa), 32'hBEEF);

    // Scenario 3: clr, dropped write, clr during sweep ignored
    bus.clr = 1;
    tick();
    bus.clr = 0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 1) begin
        bus.w = 1; bus.select_register = 4'd5; bus.s = 16'h5555;
      end else if (n == 2) begin
        check("w_err_pulse", 32'(bus.w_err), 32'd1);
        bus.w = 0; bus.clr = 1;
      end else if (n == 3) begin
        check("w_err_clear", 32'(bus.w_err), 32'd0);
        bus.clr = 0;
      end
      tick();
    end
    check("busy_len_clr", n, 32'd16);
    bus.ra = 4'd5; bus.rb = 4'd3;
    tick();
    check("reg5_after_drop", 32'(bus.qa), 32'h0000);
    check("reg3_reloaded",   32'(bus.qb), 32'h0001);

    // Scenario 4: rst at sweep index 8 restarts the sweep
    bus.clr = 1;
    tick();
    bus.clr = 0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 9) rst = 1'b1;
      else if (n == 10) begin
        check("midrst_qa", 32'(bus.qa), 32'd0);
        rst = 1'b0;
      end
      tick();
    end
    check("busy_len_midrst", n, 32'd25);

    // Scenario 5: same-edge write/read collision
    bus.ra = 4'd2; bus.rb = 4'd2;
    bus.w = 1; bus.select_register = 4'd2; bus.s = 16'h1234;
    tick();
`ifdef BANCO_BYPASS_EN
    check("collide_qa", 32'(bus.qa), 32'h1234);
    check("collide_qb", 32'(bus.qb), 32'h1234);
`else
    check("collide_qa", 32'(bus.qa), 32'h0001);
    check("collide_qb", 32'(bus.qb), 32'h0001);
`endif
    bus.w = 0;
    tick();
    check("after_collide_qa", 32'(bus.qa), 32'h1234);

    // Scenario 6: N=8, DEPTH=32
    rst8 = 1'b0;
    n = 0;
    while (bus8.busy && n < 100) begin n++; tick(); end
    check("busy_len_n8", n, 32'd32);
    bus8.ra = 5'd14; bus8.rb = 5'd20;
    tick();
    check("n8_idx14", 32'(bus8.qa), 32'h04);
    check("n8_idx20", 32'(bus8.qb), 32'h00);
    bus8.ra = 5'd6; bus8.rb = 5'd9;
    tick();
    check("n8_idx6", 32'(bus8.qa), 32'h25);
    check("n8_idx9", 32'(bus8.qb), 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/banco_registros.md
BANCO_REGISTROS -- requirements
Module: banco_registros

Interface
REQ-001 Parameter N, default 16: data width in bits.
REQ-002 Parameter DEPTH, default 16: register count, power of two, at least 2; AW = log2(DEPTH) is derived, not overridable.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 w  in  1  write request.
REQ-006 select_register  in  AW  write address.
REQ-007 s  in  N  write data.
REQ-008 ra, rb  in  AW each  read addresses, ports A and B.
REQ-009 qa, qb  out  N each  registered read data.
REQ-010 clr  in  1  request to reload all registers with preset values.
REQ-011 busy  out  1  high while a preset sweep is in progress.
REQ-012 w_err  out  1  one-cycle pulse when a write is dropped.

Function
REQ-013 FSM states:
- IDLE to SWEEP on clr=1.
- SWEEP to IDLE on the edge that writes index DEPTH-1.
- clr in SWEEP is ignored; the sweep does not restart.
REQ-014 busy = (state == SWEEP), combinational from state.
REQ-015 SWEEP behaviour:
- each edge writes PRESET[cnt] into reg[cnt], then cnt increments.
- one register per cycle, ascending from 0.
- the sweep takes exactly DEPTH cycles.
REQ-016 PRESET, index 0..15: 0x0001 x4, 0x0000 x2, 0x0025, 0x0000 x2, 0x0404, 0x0004 x3, 0x8004, 0xA204, 0x8004.
- Entries at index 16 and above are 0.
- Each entry is truncated or zero-extended to N bits.
REQ-017 Writes in IDLE: w=1 writes s into reg[select_register] at the edge.
REQ-018 Writes in SWEEP: w=1 is dropped, and w_err=1 on the following cycle.
- w_err is 0 in all other cycles.
REQ-019 Read latency is 1 cycle: qa <= reg[ra] and qb <= reg[rb] on every edge, in every state.
REQ-020 Same-edge collision: a read of an address being written (by user write or sweep) returns the pre-write contents, unless the bypass macro applies (REQ-025).
REQ-021 qa and qb always reflect the registers as they stand, including a partially swept array.

Reset
REQ-022 rst=1 at an edge sets the following, overriding every other input:
- state = SWEEP, cnt = 0.
- qa = qb = 0, w_err = 0.
- busy is therefore 1.
REQ-023 Register storage has no direct reset.
- After rst falls, reg[k] holds PRESET[k] from edge k+1 onward.
- busy is high for exactly DEPTH cycles.
REQ-024 rst during a sweep, or any other mid-operation rst, restarts the sweep at index 0.

Configuration
REQ-025 BANCO_BYPASS_EN defined: when an accepted user write has select_register == ra (or rb) at the same edge, qa (or qb) loads s instead of the old value.
- Sweep writes are never bypassed.
REQ-026 BANCO_BYPASS_EN undefined: the REQ-020 old-value behaviour holds; no bypass logic is generated.

Structure
REQ-027 Package banco_pkg holds:
- the PRESET table constant.
- the FSM state typedef (IDLE, SWEEP).
- the default N and DEPTH constants.
REQ-028 Sub-module banco_barrido holds the FSM and sweep counter.
- Outputs: busy, sweep-write enable, sweep index.
- The storage array and read ports stay in banco_registros.

Verification
REQ-029 The bench shall cover these directed scenarios:
- rst 1 cycle, then idle: busy=1 for 16 cycles, then 0; ra=6 gives qa=0x0025; rb=14 gives qb=0xA204.
- After the sweep, w=1, select_register=3, s=0xBEEF; next cycle ra=3 gives qa=0xBEEF, w_err=0.
- clr=1, then w=1 to address 5 during busy: w_err=1 for one cycle; after busy falls, reg5=0x0000.
- rst asserted at sweep index 8 (on the 9th busy cycle): the sweep restarts and busy stays high 16 cycles from release.
- Same-edge write 0x1234 to address 2 with ra=2: qa=0x0001 without the macro, 0x1234 with BANCO_BYPASS_EN.
- N=8, DEPTH=32: index 14 reads 0x04 after the sweep, index 20 reads 0x00, and busy lasts 32 cycles.
